msdff_univ_reg: RTL

Parametrised universal register built on positive-edge master-slave storage cells. Each of the WIDTH bits is one cell. The block extends the single-bit D flip-flop with the following:
- clock enable;
- synchronous clear;
- parallel load;
- bidirectional serial shift with serial in/out on both ends;
- optional rotate.

It is the storage/shift element used by the CA3 datapath, for example operand registers and serial converters.

---
 rtl/msdff_univ_reg.sv | 125 ++++++++++++
 1 files changed

// File: rtl/msdff_univ_reg.sv
// rtl/msdff_univ_reg.sv - universal register (hold/shift R/shift L/load) on master-slave cells
// Optional feature macro: MSDFF_UNIV_REG_ROTATE_EN (turns shifts into rotates when Rot=1)

// One storage bit. The master is the next-state selection while clock is low.
// The slave is the flop that captures it on the rising edge.
module msdff_univ_cell (
  input  logic       clock,
  input  logic       Reset,
  input  logic       en,
  input  logic       clr,
  input  logic [1:0] mode,
  input  logic       d,
  input  logic       from_left,
  input  logic       from_right,
  output logic       q
);

  logic master;

  // Master: choose what the slave takes at the next rising edge.
  always_comb begin
    master = q;
    if (en) begin
      if (clr) begin
        master = 1'b0;
      end else begin
        unique case (mode)
          2'b00:   master = q;
          2'b01:   master = from_left;
          2'b10:   master = from_right;
          default: master = d;
        endcase
      end
    end
  end

  // Slave: updates only on the rising edge; reset clears it at once.
  always_ff @(posedge clock or negedge Reset) begin
    if (!Reset) begin
      q <= 1'b0;
    end else begin
      q <= master;
    end
  end

endmodule

module msdff_univ_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             Reset,
  input  logic             En,
  input  logic             Clr,
  input  logic [1:0]       Mode,
  input  logic [WIDTH-1:0] D,
  input  logic             SerInR,
  input  logic             SerInL,
  input  logic             Rot,
  output logic [WIDTH-1:0] Q,
  output logic             SerOutR,
  output logic             SerOutL,
  output logic             Zero
);

  logic top_in;
  logic bot_in;

`ifdef MSDFF_UNIV_REG_ROTATE_EN
  // End bits: with Rot the opposite end of Q wraps around instead of the serial input.
  always_comb begin
    top_in = Rot ? Q[0] : SerInR;
    bot_in = Rot ? Q[WIDTH-1] : SerInL;
  end
`else
  logic rot_unused;

  // End bits: shifts always take the serial inputs; Rot has no effect.
  always_comb begin
    top_in     = SerInR;
    bot_in     = SerInL;
    rot_unused = Rot;
  end
`endif

  genvar i;
  generate
    for (i = 0; i < WIDTH; i++) begin : g_cell
      logic left_bit;
      logic right_bit;

      if (i == WIDTH - 1) begin : g_top
        assign left_bit = top_in;
      end else begin : g_mid_l
        assign left_bit = Q[i+1];
      end

      if (i == 0) begin : g_bot
        assign right_bit = bot_in;
      end else begin : g_mid_r
        assign right_bit = Q[i-1];
      end

      msdff_univ_cell u_cell (
        .clock      (clock),
        .Reset      (Reset),
        .en         (En),
        .clr        (Clr),
        .mode       (Mode),
        .d          (D[i]),
        .from_left  (left_bit),
        .from_right (right_bit),
        .q          (Q[i])
      );
    end
  endgenerate

  // Serial outputs and zero flag follow Q directly so cascaded stages add no latency.
  always_comb begin
    SerOutR = Q[0];
    SerOutL = Q[WIDTH-1];
    Zero    = (Q == '0);
  end

endmodule
